// File: rtl/aes_sbox_pkg.sv
// Shared types and GF(2^8) helper for the shared S-box scheduler.
// Field polynomial x^8+x^4+x^3+x+1.
package aes_sbox_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLK,
    KEY
  } state_e;

  localparam int BLK_BYTES = 16;
  localparam int KW_BYTES  = 4;

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] r;
    logic [7:0] t;
    r = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

endpackage

// File: rtl/canright_sbox.sv
// Single-byte AES S-box, forward or inverse, purely combinational.
// Field inversion is x^254, wrapped by the (inverse) affine map.
module canright_sbox
  import aes_sbox_pkg::*;
(
  input  logic [7:0] in_i,
  input  logic       encrypt_i,
  output logic [7:0] out_o
);

  function automatic logic [7:0] rotl(
    input logic [7:0] x,
    input int         n
  );
    logic [15:0] w;
    w = {x, x} << n;
    return w[15:8];
  endfunction

  logic [7:0] pre;
  logic [7:0] p;
  logic [7:0] r;

  always_comb begin
    pre = in_i;
    if (!encrypt_i)
      pre = rotl(in_i, 1) ^ rotl(in_i, 3)
          ^ rotl(in_i, 6) ^ 8'h05;
    p = gf_mul(pre, pre);
    r = p;
    for (int k = 2; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    out_o = r;
    if (encrypt_i)
      out_o = r ^ rotl(r, 1) ^ rotl(r, 2)
            ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
  end

endmodule

// File: rtl/sbox_share_scheduler.sv
// Time-shares one S-box between a 16-byte block and key SubWord.
// Key words win each free slot unless the block has starved too long.
module sbox_share_scheduler
  import aes_sbox_pkg::*;
#(
  parameter int STARVE_LIMIT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_start,
  input  logic         blk_encrypt,
  input  logic [127:0] blk_in,
  output logic         blk_busy,
  output logic         blk_done,
  output logic [127:0] blk_out,
  input  logic         kw_req,
  input  logic [31:0]  kw_in,
  output logic         kw_ack,
  output logic         kw_valid,
  output logic [31:0]  kw_out
);

  state_e       state_q, state_d;
  logic         busy_q, done_q, enc_q;
  logic         ack_q, valid_q;
  logic [127:0] blk_q;
  logic [31:0]  kbuf_q, kout_q;
  logic [3:0]   bidx_q;
  logic [1:0]   kidx_q;
  logic [7:0]   starve_q, starve_d;

  logic       blk_fire, blk_last;
  logic       key_fire, key_last;
  logic       slot_free, start_acc, busy_nx;
  logic       starve_hit, grant;
  logic [7:0] cnt_inc;
  logic [7:0] sb_in, sb_out;
  logic       sb_enc;

  canright_sbox u_sbox (
    .in_i      (sb_in),
    .encrypt_i (sb_enc),
    .out_o     (sb_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    start_acc  = blk_start && !busy_q;
    busy_nx    = start_acc || (busy_q && !blk_last);
    cnt_inc    = starve_q + 8'(key_last && busy_q);
    starve_hit = busy_nx && (cnt_inc >= 8'(STARVE_LIMIT));
    grant      = 1'b0;
    state_d    = state_q;
    starve_d   = cnt_inc;
    if (slot_free) begin
      grant = kw_req && !starve_hit;
      if (grant) begin
        state_d  = KEY;
        starve_d = busy_nx ? cnt_inc : 8'd0;
      end else begin
        state_d  = busy_nx ? BLK : IDLE;
        starve_d = 8'd0;
      end
    end
  end

  always_comb begin
    blk_fire  = (state_q == BLK);
    key_fire  = (state_q == KEY);
    blk_last  = blk_fire && (bidx_q == 4'(BLK_BYTES - 1));
    key_last  = key_fire && (kidx_q == 2'(KW_BYTES - 1));
    slot_free = !key_fire || key_last;
    sb_enc    = key_fire || enc_q;
    sb_in     = key_fire ? kbuf_q[{kidx_q, 3'b000} +: 8]
                         : blk_q[{bidx_q, 3'b000} +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      enc_q    <= 1'b0;
      ack_q    <= 1'b0;
      valid_q  <= 1'b0;
      blk_q    <= '0;
      kbuf_q   <= '0;
      kout_q   <= '0;
      bidx_q   <= '0;
      kidx_q   <= '0;
      starve_q <= '0;
    end else begin
      busy_q   <= busy_nx;
      done_q   <= blk_last;
      ack_q    <= grant;
      valid_q  <= key_last;
      starve_q <= starve_d;
      if (start_acc) begin
        blk_q  <= blk_in;
        enc_q  <= blk_encrypt;
        bidx_q <= '0;
      end else if (blk_fire) begin
        blk_q[{bidx_q, 3'b000} +: 8] <= sb_out;
        bidx_q <= bidx_q + 4'd1;
      end
      // a new word may be captured on the edge that finishes the last one
      if (grant)
        kbuf_q <= kw_in;
      else if (key_fire)
        kbuf_q[{kidx_q, 3'b000} +: 8] <= sb_out;
      if (key_fire) kidx_q <= kidx_q + 2'd1;
      if (key_last) kout_q <= {sb_out, kbuf_q[23:0]};
    end
  end

  assign blk_busy = busy_q;
  assign blk_done = done_q;
  assign blk_out  = blk_q;
  assign kw_ack   = ack_q;
  assign kw_valid = valid_q;
  assign kw_out   = kout_q;

endmodule
